div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider: done 35 edges after start (1 PREP, 32 ITER, 1 FIX, 1 DONE).
// Optional DIV_UNIT_DIVZERO_TRAP_EN adds div_by_zero and a 2-edge early exit for divisor == 0.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [63:0] result
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
  ,
  output logic        div_by_zero
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sn_q, sn_d;
  logic        sd_q, sd_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] remo_q, remo_d;
  logic        dz_hit;
  logic [33:0] shifted;
  logic [33:0] trial;

`ifdef DIV_UNIT_DIVZERO_TRAP_EN
  logic dz_q, dz_d;
  assign dz_hit = (dsr_q == 32'd0);
`else
  assign dz_hit = 1'b0;
`endif

  // One restoring step; the extra top bit of trial acts as the borrow.
  assign shifted = {rem_q, dvd_q[31]};
  assign trial   = shifted - {2'b00, dsr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
      dz_q    <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PREP;
      S_PREP:  state_d = dz_hit ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    sn_d   = sn_q;
    sd_d   = sd_q;
    quo_d  = quo_q;
    remo_d = remo_q;
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
    dz_d   = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dsr_d = divisor;
          sn_d  = dividend[31];
          sd_d  = divisor[31];
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
          dz_d  = 1'b0;
`endif
        end
      end
      S_PREP: begin
        // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
        dvd_d = sn_q ? -dvd_q : dvd_q;
        dsr_d = sd_q ? -dsr_q : dsr_q;
        rem_d = '0;
        cnt_d = '0;
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
        if (dz_hit) begin
          quo_d  = '0;
          remo_d = dvd_q;
          dz_d   = 1'b1;
        end
`endif
      end
      S_ITER: begin
        if (!trial[33]) begin
          rem_d = trial[32:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[32:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
      end
      S_FIX: begin
        quo_d  = (sn_q ^ sd_q) ? -dvd_q : dvd_q;
        remo_d = sn_q ? -rem_q[31:0] : rem_q[31:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    quotient  = quo_q;
    remainder = remo_q;
    result    = {remo_q, quo_q};
`ifdef DIV_UNIT_DIVZERO_TRAP_EN
    div_by_zero = dz_q && (state_q == S_DONE);
`endif
  end

endmodule
